// File: rtl/regfile_arb_pkg.sv
// Shared types for the register file write-port arbiter.
// Stats counters are enabled by defining REGFILE_ARB_STATS_EN.
package regfile_arb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_MD = 1'b1
  } req_id_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write mask: one bit per register awaiting a mul/div result.
// A set and a clear of the same bit in one cycle leaves the bit set.
module regfile_scoreboard
  import regfile_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] mask
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && (set_addr != '0))
      set_vec = NUM_REGS'(1) << set_addr;
    if (clr_en)
      clr_vec = NUM_REGS'(1) << clr_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mask <= '0;
    else
      mask <= (mask & ~clr_vec) | set_vec;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between WB (req0) and mul/div (req1).
// Define REGFILE_ARB_STATS_EN to add conflict/forced-win counters.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_valid_i,
  input  logic [ADDR_W-1:0]   req0_addr_i,
  input  logic [DATA_W-1:0]   req0_data_i,
  output logic                req0_ready_o,
  input  logic                req1_valid_i,
  input  logic [ADDR_W-1:0]   req1_addr_i,
  input  logic [DATA_W-1:0]   req1_data_i,
  output logic                req1_ready_o,
  input  logic                busy_set_i,
  input  logic [ADDR_W-1:0]   busy_addr_i,
  output logic [NUM_REGS-1:0] busy_o,
`ifdef REGFILE_ARB_STATS_EN
  output logic [31:0]         conflict_cnt_o,
  output logic [31:0]         force_cnt_o,
`endif
  output logic                RegWrite_o,
  output logic [ADDR_W-1:0]   RDaddr_o,
  output logic [DATA_W-1:0]   RDdata_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  wb_req_t          wb_req;
  wb_req_t          md_req;
  wb_req_t          win;
  req_id_t          grant;
  logic             both;
  logic             same;
  logic             forced;

  assign wb_req = '{valid: req0_valid_i, addr: req0_addr_i, data: req0_data_i};
  assign md_req = '{valid: req1_valid_i, addr: req1_addr_i, data: req1_data_i};

  assign both   = req0_valid_i & req1_valid_i;
  assign same   = both & (req0_addr_i == req1_addr_i) & (|req0_addr_i);
  assign forced = both & ~same & (starve_cnt == LIMIT);

  // A same-address req1 is accepted alongside req0 and its data dropped.
  assign req0_ready_o = req0_valid_i & ~forced;
  assign req1_ready_o = req1_valid_i & (~req0_valid_i | same | forced);

  assign grant = req0_ready_o ? REQ_WB : REQ_MD;
  assign win   = (grant == REQ_WB) ? wb_req : md_req;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else begin
      RegWrite_o <= win.valid & (|win.addr);
      RDaddr_o   <= win.addr;
      RDdata_o   <= win.data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      starve_cnt <= '0;
    else if (!req1_valid_i || req1_ready_o)
      starve_cnt <= '0;
    else if (both && (starve_cnt != LIMIT))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  regfile_scoreboard u_sb (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .set_en   (busy_set_i),
    .set_addr (busy_addr_i),
    .clr_en   (req1_ready_o),
    .clr_addr (req1_addr_i),
    .mask     (busy_o)
  );

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      conflict_cnt_o <= '0;
      force_cnt_o    <= '0;
    end else begin
      if (both)
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
      if (forced)
        force_cnt_o <= force_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i, busy_set_i;
  logic [4:0]  req0_addr_i, req1_addr_i, busy_addr_i;
  logic [31:0] req0_data_i, req1_data_i;
  logic        req0_ready_o, req1_ready_o, RegWrite_o;
  logic [31:0] busy_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] conflict_cnt_o, force_cnt_o;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_addr_i  (req0_addr_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_addr_i  (req1_addr_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .busy_set_i   (busy_set_i),
    .busy_addr_i  (busy_addr_i),
    .busy_o       (busy_o),
`ifdef REGFILE_ARB_STATS_EN
    .conflict_cnt_o (conflict_cnt_o),
    .force_cnt_o    (force_cnt_o),
`endif
    .RegWrite_o   (RegWrite_o),
    .RDaddr_o     (RDaddr_o),
    .RDdata_o     (RDdata_o)
  );

  int checks = 0;
  int errors = 0;

  // Model state: consecutive req1 losses, pending mask, expected write.
  int          losses;
  bit [31:0]   mbusy;
  bit          mwe;
  bit [4:0]    maddr;
  bit [31:0]   mdata;
  bit          lr0, lr1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                       input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                       input bit bs, input bit [4:0] ba);
    req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
    req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
    busy_set_i = bs; busy_addr_i = ba;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at posedge+1: checks readies, advances one clock, checks outputs.
  task automatic step();
    bit v0, v1, both, same, forced, nwe;
    bit [4:0]  na;
    bit [31:0] nd;
    bit [31:0] nb;
    v0 = req0_valid_i; v1 = req1_valid_i;
    both   = v0 && v1;
    same   = both && (req0_addr_i == req1_addr_i) && (req0_addr_i != 0);
    forced = both && !same && (losses >= LIM);
    lr0 = v0 && !forced;
    lr1 = v1 && (!v0 || same || forced);
    #1;
    chk("req0_ready", req0_ready_o, lr0);
    chk("req1_ready", req1_ready_o, lr1);
    nwe = 0; na = 0; nd = 0;
    if (lr0) begin
      nwe = (req0_addr_i != 0); na = req0_addr_i; nd = req0_data_i;
    end else if (lr1) begin
      nwe = (req1_addr_i != 0); na = req1_addr_i; nd = req1_data_i;
    end
    nb = mbusy;
    if (lr1) nb[req1_addr_i] = 1'b0;
    if (busy_set_i && busy_addr_i != 0) nb[busy_addr_i] = 1'b1;
    if (!v1 || lr1) losses = 0;
    else if (both && losses < LIM) losses++;
    @(posedge clk); #1;
    mwe = nwe; maddr = na; mdata = nd; mbusy = nb;
    chk("RegWrite", RegWrite_o, mwe);
    if (mwe) begin
      chk("RDaddr", RDaddr_o, maddr);
      chk("RDdata", RDdata_o, mdata);
    end
    chk("busy", busy_o, mbusy);
  endtask

  task automatic model_reset();
    losses = 0; mbusy = 0; mwe = 0; maddr = 0; mdata = 0;
  endtask

  bit        p0v, p1v;
  bit [4:0]  p0a, p1a;
  bit [31:0] p0d, p1d;

  initial begin
    rst_i = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", RegWrite_o, 0);
    chk("rst_addr", RDaddr_o, 0);
    chk("rst_data", RDdata_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b1;

    // Plain req0 write
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step();
    chk("t2_we", RegWrite_o, 1);
    chk("t2_addr", RDaddr_o, 5);
    chk("t2_data", RDdata_o, 32'hDEADBEEF);
    idle();
    step();
    chk("t2_pulse", RegWrite_o, 0);

    // Starvation: req1 wins on the fifth contested cycle
    for (int i = 0; i < 6; i++) begin
      drive(1, 3, 32'h100 + i, 1, 7, 32'h700 + i, 0, 0);
      #1;
      chk("t3_r0", req0_ready_o, (i == 4) ? 1'b0 : 1'b1);
      step();
      if (i == 4) chk("t3_win", RDdata_o, 32'h704);
    end
    idle();
    step();

    // Same-address collision: req0 data kept, busy bit cleared
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    step();
    chk("t4_set", busy_o[9], 1);
    drive(1, 9, 32'hAAAA0009, 1, 9, 32'hBBBB0009, 0, 0);
    #1;
    chk("t4_r1", req1_ready_o, 1);
    step();
    chk("t4_data", RDdata_o, 32'hAAAA0009);
    chk("t4_clr", busy_o[9], 0);

    // Set wins over a same-cycle clear
    drive(0, 0, 0, 0, 0, 0, 1, 12);
    step();
    drive(0, 0, 0, 1, 12, 32'hC, 1, 12);
    step();
    chk("t5_busy", busy_o[12], 1);

    // Address 0 is accepted without a write
    drive(1, 0, 32'h1, 0, 0, 0, 0, 0);
    #1;
    chk("t6_r0", req0_ready_o, 1);
    step();
    chk("t6_we", RegWrite_o, 0);

    // Randomized traffic; requests held until accepted
    p0v = 0; p1v = 0;
    for (int n = 0; n < 400; n++) begin
      if (!p0v && ($urandom_range(0, 3) != 0)) begin
        p0v = 1; p0a = 5'($urandom_range(0, 7)); p0d = $urandom;
      end
      if (!p1v && ($urandom_range(0, 2) == 0)) begin
        p1v = 1; p1a = 5'($urandom_range(0, 7)); p1d = $urandom;
      end
      drive(p0v, p0a, p0d, p1v, p1a, p1d,
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      step();
      if (lr0) p0v = 0;
      if (lr1) p1v = 0;
    end

    // Asynchronous reset mid-stream
    drive(0, 0, 0, 0, 0, 0, 1, 6);
    step();
    drive(1, 5, 32'h55, 0, 0, 0, 0, 0);
    step();
    chk("pre_rst_we", RegWrite_o, 1);
    drive(1, 6, 32'h66, 0, 0, 0, 0, 0);
    #1;
    rst_i = 1'b0;
    #1;
    chk("arst_we", RegWrite_o, 0);
    chk("arst_addr", RDaddr_o, 0);
    chk("arst_data", RDdata_o, 0);
    chk("arst_busy", busy_o, 0);
    @(posedge clk);
    idle();
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_we", RegWrite_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
